// File: rtl/iscas_bist_driver.sv
// BIST stimulus/response engine for an ISCAS89 CUT: LFSR pattern source,
// MISR response compactor and golden-signature compare, sequenced by a small FSM.
module iscas_bist_driver #(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned N_OUT  = 6,
  parameter int unsigned N_PAT  = 255,
  parameter int unsigned LAT    = 1,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter logic [15:0] GOLDEN = 16'h0000
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             start,
  input  logic             abort,
  output logic [N_IN-1:0]  pat_out,
  output logic             pat_valid,
  input  logic [N_OUT-1:0] resp_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      signature
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [15:0] PAT_LAST   = 16'(N_PAT - 1);
  localparam logic [15:0] DRAIN_LAST = 16'(LAT - 1);
  localparam logic [15:0] MISR_POLY  = 16'h1021;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [15:0]      r_lfsr;
  logic [15:0]      r_misr;
  logic [15:0]      r_cnt;
  logic [LAT-1:0]   r_cap_pipe;

  logic             w_begin_run;
  logic             w_cap_en;
  logic [15:0]      w_lfsr_nxt;
  logic [15:0]      w_misr_nxt;
  logic [15:0]      w_resp_ext;

  // Next state; abort wins over every other transition.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_begin_run = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_state_nxt = ST_LOAD;
          w_begin_run = 1'b1;
        end
      end
      ST_LOAD:  w_state_nxt = ST_RUN;
      ST_RUN:   if (r_cnt == PAT_LAST)   w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (r_cnt == DRAIN_LAST) w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_begin_run = 1'b0;
    end
  end

  always_comb begin
    w_resp_ext              = '0;
    w_resp_ext[N_OUT-1:0]   = resp_in;
  end

  assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  assign w_misr_nxt = {r_misr[14:0], 1'b0} ^ (r_misr[15] ? MISR_POLY : 16'h0000) ^ w_resp_ext;
  // Capture strobe is the live-pattern flag delayed by the CUT latency.
  assign w_cap_en   = r_cap_pipe[LAT-1];

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CK) begin
    if (!RSTN) begin
      r_state    <= ST_IDLE;
      r_lfsr     <= SEED;
      r_misr     <= '0;
      r_cnt      <= '0;
      r_cap_pipe <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (abort || w_begin_run) begin
        r_lfsr     <= SEED;
        r_misr     <= '0;
        r_cnt      <= '0;
        r_cap_pipe <= '0;
      end else begin
        r_cap_pipe <= (r_cap_pipe << 1) | LAT'(pat_valid);
        if (w_cap_en) r_misr <= w_misr_nxt;
        case (r_state)
          ST_RUN: begin
            r_lfsr <= w_lfsr_nxt;
            // The pattern counter is reused as the drain counter, so restart it on exit.
            r_cnt  <= (r_cnt == PAT_LAST) ? 16'h0000 : r_cnt + 16'h0001;
          end
          ST_DRAIN: r_cnt <= r_cnt + 16'h0001;
          default:  r_cnt <= '0;
        endcase
      end
    end
  end

  assign pat_valid = (r_state == ST_RUN);
  assign pat_out   = pat_valid ? r_lfsr[N_IN-1:0] : '0;
  assign busy      = (r_state == ST_LOAD) || (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_misr == GOLDEN);
  assign signature = r_misr;

endmodule

// File: tb/tb_iscas_bist_driver.sv
// Self-checking bench for iscas_bist_driver: four configurations, directed timing
// scenarios plus random response streams scored against a pattern-level model.
module tb_iscas_bist_driver;

  // ---------------- reference model (pattern-level) ----------------
  function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  function automatic logic [15:0] misr_adv(input logic [15:0] m, input logic [5:0] r);
    return {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {10'b0, r};
  endfunction

  function automatic logic [5:0] cut_f(input logic [2:0] p);
    return {p[1] ^ p[0], p[2] & p[1], ~p[2], p};
  endfunction

  // Golden signature: 255 LFSR patterns through the CUT function, compacted.
  function automatic logic [15:0] gold_fn();
    logic [15:0] m;
    logic [15:0] s;
    m = 16'h0000;
    s = 16'hACE1;
    for (int i = 0; i < 255; i++) begin
      m = misr_adv(m, cut_f(s[2:0]));
      s = lfsr_adv(s);
    end
    return m;
  endfunction

  localparam logic [15:0] D_GOLD = gold_fn();

  // ---------------- clock / shared ----------------
  logic CK = 1'b0;
  always #5 CK = ~CK;
  logic RSTN;
  int total = 0;
  int bad   = 0;

  // ---------------- instances ----------------
  logic a_start, a_abort, a_pv, a_busy, a_done, a_pass;
  logic [5:0] a_resp; logic [2:0] a_pat; logic [15:0] a_sig;
  logic b_start, b_abort, b_pv, b_busy, b_done, b_pass;
  logic [5:0] b_resp; logic [2:0] b_pat; logic [15:0] b_sig;
  logic c_start, c_abort, c_pv, c_busy, c_done, c_pass;
  logic [5:0] c_resp; logic [2:0] c_pat; logic [15:0] c_sig;
  logic d_start, d_abort, d_pv, d_busy, d_done, d_pass;
  logic [5:0] d_resp; logic [2:0] d_pat; logic [15:0] d_sig;

  iscas_bist_driver #(.N_PAT(1), .LAT(1)) u_a (
    .CK(CK), .RSTN(RSTN), .start(a_start), .abort(a_abort), .pat_out(a_pat),
    .pat_valid(a_pv), .resp_in(a_resp), .busy(a_busy), .done(a_done),
    .pass(a_pass), .signature(a_sig));

  iscas_bist_driver #(.N_PAT(2), .LAT(1)) u_b (
    .CK(CK), .RSTN(RSTN), .start(b_start), .abort(b_abort), .pat_out(b_pat),
    .pat_valid(b_pv), .resp_in(b_resp), .busy(b_busy), .done(b_done),
    .pass(b_pass), .signature(b_sig));

  iscas_bist_driver #(.N_PAT(255), .LAT(3)) u_c (
    .CK(CK), .RSTN(RSTN), .start(c_start), .abort(c_abort), .pat_out(c_pat),
    .pat_valid(c_pv), .resp_in(c_resp), .busy(c_busy), .done(c_done),
    .pass(c_pass), .signature(c_sig));

  iscas_bist_driver #(.N_PAT(255), .LAT(2), .GOLDEN(D_GOLD)) u_d (
    .CK(CK), .RSTN(RSTN), .start(d_start), .abort(d_abort), .pat_out(d_pat),
    .pat_valid(d_pv), .resp_in(d_resp), .busy(d_busy), .done(d_done),
    .pass(d_pass), .signature(d_sig));

  // CUT model for u_d: two-cycle response latency.
  logic [2:0] d_p1, d_p2;
  always @(posedge CK) begin
    d_p1 <= d_pat;
    d_p2 <= d_p1;
  end
  assign d_resp = cut_f(d_p2);

  logic [5:0] c_tab [0:299];

  task automatic step();
    @(posedge CK);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RSTN = 1'b0;
    a_start = 0; a_abort = 0; a_resp = '0;
    b_start = 0; b_abort = 0; b_resp = '0;
    c_start = 0; c_abort = 0; c_resp = '0;
    d_start = 0; d_abort = 0;
    step(); step();
    total++; if ({a_busy, a_done, a_pass, a_pv, a_pat, a_sig} !== '0) begin bad++;
      $display("FAIL reset_a got=%h want=0", {a_busy, a_done, a_pass, a_pv, a_pat, a_sig}); end
    total++; if ({b_busy, b_done, b_pass, b_pv, b_pat, b_sig} !== '0) begin bad++;
      $display("FAIL reset_b got=%h want=0", {b_busy, b_done, b_pass, b_pv, b_pat, b_sig}); end
    total++; if ({c_busy, c_done, c_pass, c_pv, c_pat, c_sig} !== '0) begin bad++;
      $display("FAIL reset_c got=%h want=0", {c_busy, c_done, c_pass, c_pv, c_pat, c_sig}); end
    total++; if ({d_busy, d_done, d_pass, d_pv, d_pat, d_sig} !== '0) begin bad++;
      $display("FAIL reset_d got=%h want=0", {d_busy, d_done, d_pass, d_pv, d_pat, d_sig}); end
    RSTN = 1'b1;
    step();
  endtask

  task automatic test_single();
    a_start = 1; step(); a_start = 0;                       // cycle 1: LOAD
    total++; if ({a_busy, a_pv} !== 2'b10) begin bad++;
      $display("FAIL single_load busy,pv got=%b want=10", {a_busy, a_pv}); end
    step();                                                 // cycle 2: RUN
    total++; if ({a_pv, a_pat} !== 4'b1_001) begin bad++;
      $display("FAIL single_pat pv,pat got=%b want=1001", {a_pv, a_pat}); end
    a_resp = 6'h01;
    step();                                                 // cycle 3: DRAIN
    total++; if ({a_busy, a_pv, a_pat, a_done} !== 6'b10_000_0) begin bad++;
      $display("FAIL single_drain got=%b want=100000", {a_busy, a_pv, a_pat, a_done}); end
    step();                                                 // cycle 4: DONE
    total++; if ({a_done, a_pass, a_busy} !== 3'b100) begin bad++;
      $display("FAIL single_done done,pass,busy got=%b want=100", {a_done, a_pass, a_busy}); end
    total++; if (a_sig !== 16'h0001) begin bad++;
      $display("FAIL single_sig got=%h want=0001", a_sig); end
  endtask

  task automatic test_two_pat();
    logic [2:0] exp_pat [2:3];
    exp_pat[2] = 3'b001; exp_pat[3] = 3'b000;
    b_resp = 6'h01;
    b_start = 1;
    for (int k = 1; k <= 5; k++) begin
      step(); b_start = 0;
      total++; if (b_busy !== (k >= 1 && k <= 4)) begin bad++;
        $display("FAIL two_busy cycle=%0d got=%b want=%b", k, b_busy, (k >= 1 && k <= 4)); end
      if (k == 2 || k == 3) begin
        total++; if ({b_pv, b_pat} !== {1'b1, exp_pat[k]}) begin bad++;
          $display("FAIL two_pat cycle=%0d got=%b want=%b", k, {b_pv, b_pat}, {1'b1, exp_pat[k]}); end
      end
    end
    total++; if ({b_done, b_pass, b_sig} !== {2'b10, 16'h0003}) begin bad++;
      $display("FAIL two_sig1 got=%b_%h want=10_0003", {b_done, b_pass}, b_sig); end
    // Restart from DONE with a quiet CUT: zero signature passes against GOLDEN=0.
    b_resp = 6'h00;
    b_start = 1; step(); b_start = 0;
    total++; if ({b_done, b_pass, b_sig} !== 18'h0) begin bad++;
      $display("FAIL two_reload got=%b_%h want=00_0000", {b_done, b_pass}, b_sig); end
    repeat (4) step();
    total++; if ({b_done, b_pass, b_sig} !== {2'b11, 16'h0000}) begin bad++;
      $display("FAIL two_sig0 got=%b_%h want=11_0000", {b_done, b_pass}, b_sig); end
  endtask

  task automatic test_busy_start();
    b_resp = 6'h01;
    b_start = 1; step(); b_start = 0;                       // cycle 1
    step(); b_start = 1;                                    // cycles 2..4 hold start
    step(); step();                                         // cycle 4
    total++; if (b_done !== 1'b0) begin bad++;
      $display("FAIL busy_start_early got=%b want=0", b_done); end
    step(); b_start = 0;                                    // cycle 5
    total++; if ({b_done, b_sig} !== {1'b1, 16'h0003}) begin bad++;
      $display("FAIL busy_start_done got=%b_%h want=1_0003", b_done, b_sig); end
    step(); step();
    total++; if ({b_done, b_busy} !== 2'b10) begin bad++;
      $display("FAIL busy_start_hold got=%b want=10", {b_done, b_busy}); end
    b_abort = 1; b_start = 1; step(); b_abort = 0; b_start = 0;
    total++; if ({b_done, b_pass, b_busy, b_sig} !== 19'h0) begin bad++;
      $display("FAIL abort_done got=%b_%h want=000_0000", {b_done, b_pass, b_busy}, b_sig); end
  endtask

  task automatic test_reset_drain();
    a_resp = 6'h3F;
    a_start = 1; step(); a_start = 0;
    step(); step();                                         // cycle 3: DRAIN
    RSTN = 0; step(); RSTN = 1;
    total++; if ({a_busy, a_done, a_pass, a_pv, a_pat, a_sig} !== '0) begin bad++;
      $display("FAIL reset_drain got=%h want=0", {a_busy, a_done, a_pass, a_pv, a_pat, a_sig}); end
    step();
    total++; if ({a_busy, a_done, a_sig} !== '0) begin bad++;
      $display("FAIL reset_drain_idle got=%h want=0", {a_busy, a_done, a_sig}); end
  endtask

  // One u_c run with resp[k] = c_tab[k] in cycle k; abort_at>0 aborts in RUN.
  task automatic run_c(input int abort_at, output logic [15:0] sig_out);
    logic [15:0] s;
    logic [15:0] m;
    logic        ev;
    s = 16'hACE1;
    m = 16'h0000;
    for (int k = 5; k <= 259; k++) m = misr_adv(m, c_tab[k]);
    c_resp = c_tab[0];
    c_start = 1;
    for (int k = 1; k <= 262; k++) begin
      step(); c_start = 0; c_resp = c_tab[k];
      if (abort_at > 0 && k == abort_at + 1) begin
        c_abort = 0;
        total++; if ({c_busy, c_pv, c_done, c_sig} !== 19'h0) begin bad++;
          $display("FAIL abort_run got=%b_%h want=000_0000", {c_busy, c_pv, c_done}, c_sig); end
        break;
      end
      ev = (k >= 2 && k <= 256);
      total++; if ({c_pv, c_pat} !== {ev, ev ? s[2:0] : 3'b000}) begin bad++;
        $display("FAIL rand_pat cycle=%0d got=%b want=%b", k, {c_pv, c_pat}, {ev, ev ? s[2:0] : 3'b000}); end
      if (ev) s = lfsr_adv(s);
      total++; if ({c_busy, c_done} !== {(k <= 259), (k >= 260)}) begin bad++;
        $display("FAIL rand_state cycle=%0d got=%b want=%b", k, {c_busy, c_done}, {(k <= 259), (k >= 260)}); end
      if (k == abort_at) c_abort = 1;
    end
    if (abort_at == 0) begin
      total++; if ({c_sig, c_pass} !== {m, (m == 16'h0000)}) begin bad++;
        $display("FAIL rand_sig got=%h/%b want=%h/%b", c_sig, c_pass, m, (m == 16'h0000)); end
    end
    sig_out = c_sig;
  endtask

  task automatic fill_tab();
    for (int k = 0; k < 300; k++) c_tab[k] = 6'($urandom);
  endtask

  task automatic test_back_to_back_and_abort();
    logic [15:0] sig1, sig2, sig3, unused;
    fill_tab();
    run_c(0, sig1);
    fill_tab();
    run_c(0, sig2);                                         // starts straight from DONE
    run_c(100, unused);
    step();
    run_c(0, sig3);
    total++; if (sig3 !== sig2) begin bad++;
      $display("FAIL abort_rerun got=%h want=%h", sig3, sig2); end
  endtask

  task automatic test_golden();
    d_start = 1; step(); d_start = 0;
    for (int k = 1; k <= 270; k++) begin
      if (k >= 250) begin
        total++; if (d_pass !== (k >= 259)) begin bad++;
          $display("FAIL gold_pass cycle=%0d got=%b want=%b", k, d_pass, (k >= 259)); end
      end
      if (k < 270) step();
    end
    total++; if (d_sig !== D_GOLD) begin bad++;
      $display("FAIL gold_sig got=%h want=%h", d_sig, D_GOLD); end
    d_start = 1; step(); d_start = 0;
    total++; if ({d_pass, d_done, d_busy} !== 3'b001) begin bad++;
      $display("FAIL gold_restart got=%b want=001", {d_pass, d_done, d_busy}); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_pat();
    test_busy_start();
    test_reset_drain();
    test_back_to_back_and_abort();
    test_golden();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
